// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Single-clock matrix keypad front end. A tick enable divides clk down to the
// scan rate; the driven row rotates while no column is active, a candidate
// column pattern is debounced for DEB_TICKS ticks, and confirmed single-key
// presses are queued as codes (row*NCOLS + col) in a small FIFO with a
// valid/ready handshake. Release is debounced the same way before scanning
// resumes on the next row. Extra keys pressed while a key is held are ignored.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When defined, a held single key re-pushes its code every 16*DEB_TICKS ticks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   cols       raw column lines, active-low
//   rows       row drive, one-hot active-low
//   key_code   head-of-FIFO key code
//   key_valid  FIFO non-empty
//   key_ready  consumer accepts head when key_valid && key_ready
//   key_held   high while a press is held
//   overflow   one-cycle pulse when a confirmed press is dropped on full FIFO
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 4,
  parameter int SCAN_DIV   = 2400,
  parameter int DEB_TICKS  = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCOLS-1:0]               cols,
  output logic [NROWS-1:0]               rows,
  output logic [$clog2(NROWS*NCOLS)-1:0] key_code,
  output logic                           key_valid,
  input  logic                           key_ready,
  output logic                           key_held,
  output logic                           overflow
);

  localparam int CODE_W = $clog2(NROWS*NCOLS);
  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W  = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int COL_W  = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int CNT_W  = $clog2(DEB_TICKS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int AW     = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [NCOLS-1:0] v);
    is_onehot = (v != '0) && ((v & (v - NCOLS'(1))) == '0);
  endfunction

  // Index of the lowest set bit; only meaningful for one-hot input.
  function automatic logic [COL_W-1:0] col_index(input logic [NCOLS-1:0] v);
    col_index = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (v[i]) col_index = COL_W'(i);
    end
  endfunction

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_s;
  logic [NCOLS-1:0]  sync1_q, sync2_q, act_s;
  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, row_next_s;
  logic [NCOLS-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_s;
  logic [CODE_W-1:0] code_s;
`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_TICKS = 16 * DEB_TICKS;
  localparam int RPT_W     = $clog2(RPT_TICKS + 1);
  logic [RPT_W-1:0]  rpt_q, rpt_d;
`endif

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic              full_s, empty_s, empty_d_s, pop_s, push_ok_s, ovf_s;
  logic [NROWS-1:0]  rows_q, rows_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_held_q, overflow_q;

  assign rows      = rows_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

  // Tick divider and column synchroniser next-state.
  always_comb begin
    tick_s     = (tick_cnt_q == TICK_W'(SCAN_DIV - 1));
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + TICK_W'(1);
    act_s      = ~sync2_q;
    row_next_s = (row_q == ROW_W'(NROWS - 1)) ? '0 : row_q + ROW_W'(1);
    code_s     = CODE_W'(row_q) * CODE_W'(NCOLS) + CODE_W'(col_index(cand_q));
  end

  // Scan / debounce / hold state machine.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push_s  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (tick_s) begin
          if (act_s == '0) begin
            row_d = row_next_s;
          end else begin
            cand_d  = act_s;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DEBOUNCE: begin
        if (tick_s) begin
          if (act_s == cand_q) begin
            if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
              // Multi-key patterns still lock out but produce no code.
              cnt_d   = '0;
              state_d = ST_HELD;
              push_s  = is_onehot(cand_q);
`ifdef KEYPAD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_DEBOUNCE;
        end
      end
      ST_HELD: begin
        if (tick_s) begin
          if (act_s == '0) begin
            if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
              cnt_d   = '0;
              state_d = ST_SCAN;
              row_d   = row_next_s;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if ((act_s == cand_q) && is_onehot(cand_q)) begin
              if (rpt_q == RPT_W'(RPT_TICKS - 1)) begin
                rpt_d  = '0;
                push_s = 1'b1;
              end else begin
                rpt_d = rpt_q + RPT_W'(1);
              end
            end else begin
              rpt_d = rpt_q;
            end
`endif
          end
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d = ST_SCAN;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO pointer arithmetic, head-of-queue selection and row drive pattern.
  always_comb begin
    empty_s   = (wr_q == rd_q);
    full_s    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    pop_s     = !empty_s && key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok_s = push_s && (!full_s || pop_s);
    ovf_s     = push_s && full_s && !pop_s;
    wr_d      = wr_q + AW'(push_ok_s);
    rd_d      = rd_q + AW'(pop_s);
    empty_d_s = (wr_d == rd_d);
    if (empty_d_s) begin
      key_code_d = key_code_q;
    end else if (push_ok_s && (rd_d == wr_q)) begin
      key_code_d = code_s;
    end else begin
      key_code_d = mem_q[rd_d[PTR_W-1:0]];
    end
    rows_d        = '1;
    rows_d[row_d] = 1'b0;
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      state_q     <= ST_SCAN;
      row_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      rows_q      <= ~NROWS'(1);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync1_q     <= cols;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      row_q       <= row_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rows_q      <= rows_d;
      key_code_q  <= key_code_d;
      key_valid_q <= !empty_d_s;
      key_held_q  <= (state_d == ST_HELD);
      overflow_q  <= ovf_s;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat interval counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  // FIFO storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok_s) begin
      mem_q[wr_q[PTR_W-1:0]] <= code_s;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 4;
  localparam int DT = 3;
  localparam int FD = 4;
  localparam int LAT_MAX = NR*SD + (DT+2)*SD + 4;
  localparam int REL_MAX = (DT+2)*SD + 4;
`ifdef KEYPAD_REPEAT_EN
  localparam int REPEATS = 3;
`else
  localparam int REPEATS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overflow;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;   // 0: hold off, 1: always accept, 2: random
  int ovf_seen = 0;
  int ovf_exp = 0;
  int exp_q[$];

  typedef struct {
    int r;
    int c;
    int hold;
    int code;
  } press_t;
  press_t tbl[6];

  keypad_scanner #(.NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DEB_TICKS(DT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    cols = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && !rows[r]) cols[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer and scoreboard: pops are compared against the expected order.
  always @(negedge clk) begin
    case (ready_mode)
      0: key_ready = 1'b0;
      1: key_ready = 1'b1;
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
    if (overflow === 1'b1) ovf_seen++;
    if (!reset && key_valid === 1'b1 && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=code %0d required=no pop", key_code);
      end else begin
        chk("pop_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference FIFO: bounded queue, presses beyond capacity are overflows.
  task automatic model_push(input int code);
    if (exp_q.size() >= FD) ovf_exp++;
    else exp_q.push_back(code);
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int code, input bit expect_push);
    logic [3:0] er;
    int n;
    if (expect_push) model_push(code);
    pressed[r*NC+c] = 1'b1;
    n = 0;
    while (key_held !== 1'b1 && n < LAT_MAX) begin @(negedge clk); n++; end
    chk("held_rise", 32'(key_held), 32'd1);
    er = ~(4'b0001 << r);
    chk("row_frozen", 32'(rows), 32'(er));
    repeat (hold) @(negedge clk);
    chk("row_frozen_hold", 32'(rows), 32'(er));
    pressed[r*NC+c] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < REL_MAX) begin @(negedge clk); n++; end
    chk("held_fall", 32'(key_held), 32'd0);
    er = ~(4'b0001 << ((r + 1) % NR));
    chk("row_resume", 32'(rows), 32'(er));
  endtask

  task automatic drain();
    int n;
    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("valid_after_drain", 32'(key_valid), 32'd0);
    chk("ovf_count", 32'(ovf_seen), 32'(ovf_exp));
  endtask

  initial begin
    logic [3:0] er;
    int n;
    int ovk[5][2];
    tbl[0] = '{2, 2, 5, 10};
    tbl[1] = '{0, 1, 0, 1};
    tbl[2] = '{3, 3, 12, 15};
    tbl[3] = '{1, 0, 3, 4};
    tbl[4] = '{0, 0, 20, 0};
    tbl[5] = '{3, 2, 7, 14};
    ovk[0] = '{0, 2}; ovk[1] = '{1, 1}; ovk[2] = '{2, 3}; ovk[3] = '{3, 0}; ovk[4] = '{2, 1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rows", 32'(rows), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Idle sweep: row advances every SD clocks after reset release
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((k / SD) % NR));
      chk("idle_rows", 32'(rows), 32'(er));
    end
    chk("idle_valid", 32'(key_valid), 32'd0);

    // Table of single presses
    ready_mode = 2;
    for (int i = 0; i < 6; i++) press_key(tbl[i].r, tbl[i].c, tbl[i].hold, tbl[i].code, 1'b1);
    drain();

    // Bounce on key (0,1), then a stable hold
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      pressed[1] = 1'b1;
      repeat (SD) @(negedge clk);
      pressed[1] = 1'b0;
      repeat (SD) @(negedge clk);
      chk("bounce_no_hold", 32'(key_held), 32'd0);
    end
    press_key(0, 1, 4, 1, 1'b1);
    drain();

    // Two keys on row 1: lockout without a code
    ready_mode = 2;
    pressed[1*NC+0] = 1'b1;
    pressed[1*NC+3] = 1'b1;
    n = 0;
    while (key_held !== 1'b1 && n < LAT_MAX) begin @(negedge clk); n++; end
    chk("multi_held", 32'(key_held), 32'd1);
    chk("multi_row", 32'(rows), 32'hD);
    repeat (8) @(negedge clk);
    chk("multi_no_push", 32'(key_valid), 32'd0);
    pressed[1*NC+0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("multi_partial", 32'(key_held), 32'd1);
    pressed[1*NC+3] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < REL_MAX) begin @(negedge clk); n++; end
    chk("multi_release", 32'(key_held), 32'd0);
    chk("multi_resume", 32'(rows), 32'hB);
    drain();

    // Five presses with no consumer: fifth overflows
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      press_key(ovk[i][0], ovk[i][1], 0, ovk[i][0]*NC + ovk[i][1], 1'b1);
      chk("ovf_valid", 32'(key_valid), 32'd1);
    end
    chk("ovf_pulse", 32'(ovf_seen), 32'(ovf_exp));
    chk("ovf_head", 32'(key_code), 32'd2);
    drain();
    chk("code_hold_empty", 32'(key_code), 32'd12);

    // Reset during debounce flushes everything
    ready_mode = 0;
    press_key(0, 2, 0, 2, 1'b1);
    press_key(1, 1, 0, 5, 1'b1);
    pressed[2*NC+0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("deb_not_held", 32'(key_held), 32'd0);
    chk("deb_fifo_full2", 32'(key_valid), 32'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_rows", 32'(rows), 32'hE);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_held", 32'(key_held), 32'd0);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_valid", 32'(key_valid), 32'd0);
    chk("post_rst_held", 32'(key_held), 32'd0);

    // Long hold of code 5 (auto-repeat when enabled)
    ready_mode = 2;
    for (int i = 0; i < REPEATS; i++) model_push(5);
    press_key(1, 1, 100*SD, 5, 1'b0);
    drain();

    // Randomised presses with glitches on random keys in between
    ready_mode = 2;
    for (int it = 0; it < 10; it++) begin
      int r, c, g;
      r = $urandom_range(0, NR-1);
      c = $urandom_range(0, NC-1);
      g = $urandom_range(0, NR*NC-1);
      pressed[g] = 1'b1;
      repeat ($urandom_range(1, SD)) @(negedge clk);
      pressed[g] = 1'b0;
      repeat ($urandom_range(12, 20)) @(negedge clk);
      press_key(r, c, $urandom_range(0, 30), r*NC + c, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Parametrised single-clock matrix keypad front end: row sweep, column synchronisation, debounce and key-event buffering.
- Replaces the separate divided-clock row sweeper, synchronisers, debouncers and stop clamp with one block running on `clk` plus internal tick enables.
- Delivers debounced key codes through a FIFO with a valid/ready handshake for the digit register / display logic downstream.

## Interface
Parameters:
- NROWS, 4, number of keypad rows driven
- NCOLS, 4, number of keypad columns sensed
- SCAN_DIV, 2400, clk cycles per scan tick (≥2)
- DEB_TICKS, 20, consecutive stable ticks required to accept a press or release (≥1)
- FIFO_DEPTH, 4, key events buffered (power of two, ≥2)

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cols  input  NCOLS  raw column lines, active-low (pulled up, low = key closed on driven row)
- rows  output  NROWS  row drive, one-hot active-low
- key_code  output  $clog2(NROWS*NCOLS)  head-of-FIFO code = row*NCOLS + col
- key_valid  output  1  FIFO non-empty
- key_ready  input  1  consumer accepts head when key_valid && key_ready
- key_held  output  1  high in HELD state
- overflow  output  1  one-cycle pulse when a confirmed press is dropped on full FIFO

## Operation
- Tick counter counts 0..SCAN_DIV-1 and wraps; `tick` is high the cycle it equals SCAN_DIV-1.
- `cols` pass through a 2-flop synchroniser; `act` = inverted synchronised cols. All decisions use `act` sampled on tick.
- States:
  - SCAN: on tick, if act == 0, row index advances (NROWS-1 wraps to 0); else latch act as `cand`, clear debounce count, go DEBOUNCE with row frozen.
  - DEBOUNCE: on tick, act == cand increments count, else return to SCAN (row unchanged). When count reaches DEB_TICKS: if cand is one-hot, push code and go HELD; otherwise (multi-key) go HELD with no push.
  - HELD: row frozen; on tick, act == 0 increments release count, any nonzero act clears it. At DEB_TICKS go SCAN and advance row.
- Additional keys pressed in HELD are ignored (lockout).
- FIFO: circular buffer with one extra bit in read/write pointers.
  - Push on full drops the code and pulses overflow, except when a pop occurs the same cycle: then both happen with no drop.
  - Pop on empty is ignored. key_code holds the last head value when empty.
- Reset mid-operation: everything returns to reset state immediately, FIFO flushed, pending debounce discarded.

## Timing
- Reset values: rows = all ones except bit 0 low; key_valid 0; key_code 0; key_held 0; overflow 0; state SCAN; row index 0; all counters 0.
- Row change appears on `rows` the cycle after the tick that advances it.
- Press latency: push occurs on the tick completing the DEB_TICKS-th match; key_valid rises the next cycle.
- Input-to-event: 2 sync cycles + at most one tick + DEB_TICKS ticks from stable column low on the driven row.
- Pop: key_valid/key_code update the cycle after the handshake.
- overflow and the push attempt occur in the same cycle.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in HELD with a one-hot cand still active, an internal counter pushes the same code again every 16*DEB_TICKS ticks. The counter resets on entry to HELD and on every repeat. Repeat pushes follow the normal FIFO full/overflow rules.
- Not defined: exactly one push per press; repeat counter is absent from the netlist.

## Test plan
All scenarios use NROWS=4, NCOLS=4, SCAN_DIV=4, DEB_TICKS=3, FIFO_DEPTH=4.
- Reset release, cols=4'hF for 40 cycles -> rows cycles 4'hE,4'hD,4'hB,4'h7 every 4 cycles; key_valid stays 0.
- Hold cols[2] low while rows=4'hB (row 2) -> one push of code 10, key_valid high, key_held high; release -> SCAN resumes at row 3 after 3 idle ticks.
- Bounce cols[1] (low 1 tick, high 1 tick, repeated), then hold low on row 0 -> no push during bounce; a single code 1 after 3 stable ticks.
- Cols 0 and 3 low together on row 1 -> no push; key_held high until both released.
- Five presses with key_ready=0 -> key_valid stays high, 4 codes stored, overflow pulses once on the 5th. Set key_ready=1 -> codes drain in press order, key_valid falls after the 4th pop. Also assert reset mid-DEBOUNCE -> FIFO empty, rows=4'hE.
- With `KEYPAD_REPEAT_EN`, hold code 5 for 100 ticks -> pushes at press and every 48 ticks (3 total, extras dropped with overflow if FIFO full). Without the macro -> exactly 1 push.
